// File: rtl/panel_scan_pkg.sv
// panel_scan_pkg: state encodings, default geometry and frame-pair timing helper
package panel_scan_pkg;
  localparam int CLK_DIV_DEF = 4;
  localparam int OUT_BITS_DEF = 32;
  localparam int IN_BITS_DEF = 24;
  localparam int GAP_TICKS_DEF = 16;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_OUT_SHIFT = 3'd1;
  localparam state_t S_OUT_LATCH = 3'd2;
  localparam state_t S_IN_LOAD = 3'd3;
  localparam state_t S_IN_SHIFT = 3'd4;
  localparam state_t S_GAP = 3'd5;
  function automatic int frame_ticks(input int out_bits, input int in_bits, input int gap_ticks);
    return 2 * out_bits + 2 + 2 + 2 * in_bits + gap_ticks;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: CLK_DIV prescaler emitting a one-clk tick, with synchronous clear
module scan_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/panel_scan_scheduler.sv
// panel_scan_scheduler: alternates 595 lamp output frames and 165 switch input frames.
// Define PANEL_SCAN_CONFIRM_EN to publish an input frame only when two consecutive captures agree.
module panel_scan_scheduler
  import panel_scan_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int IN_BITS = IN_BITS_DEF,
  parameter int GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_en,
  input  logic refresh,
  input  logic [OUT_BITS-1:0] out_data_0,
  input  logic [OUT_BITS-1:0] out_data_1,
  output logic [IN_BITS-1:0] in_data_0,
  output logic [IN_BITS-1:0] in_data_1,
  output logic [IN_BITS-1:0] in_data_2,
  output logic in_valid,
  output logic busy,
  output logic out_srclk,
  output logic out_rclk,
  output logic out_ser_0,
  output logic out_ser_1,
  output logic in_clk,
  output logic in_shldn,
  input  logic in_qh_0,
  input  logic in_qh_1,
  input  logic in_qh_2
);
  state_t state, state_n;
  logic ph, tick, gap_exit, start, sample, fin, publish;
  logic last_out, last_in, last_gap;
  logic [15:0] bcnt;
  logic [OUT_BITS-1:0] osr0, osr1;
  logic [IN_BITS-1:0] cap0, cap1, cap2, nxt0, nxt1, nxt2;
  logic [3*IN_BITS-1:0] frame;
  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst(reset),
    .clr(state == S_IDLE || gap_exit),
    .tick(tick)
  );
  assign last_out = bcnt == 16'(OUT_BITS - 1);
  assign last_in = bcnt == 16'(IN_BITS - 1);
  assign last_gap = bcnt == 16'(GAP_TICKS - 1);
  assign gap_exit = state == S_GAP && (refresh || (tick && last_gap));
  assign start = scan_en && (state == S_IDLE || gap_exit);
  assign sample = state == S_IN_SHIFT && tick && !ph;
  assign fin = sample && last_in;
  assign nxt0 = {cap0[IN_BITS-2:0], in_qh_0};
  assign nxt1 = {cap1[IN_BITS-2:0], in_qh_1};
  assign nxt2 = {cap2[IN_BITS-2:0], in_qh_2};
  assign frame = {nxt0, nxt1, nxt2};
`ifdef PANEL_SCAN_CONFIRM_EN
  logic [3*IN_BITS-1:0] cand;
  assign publish = frame == cand;
  always_ff @(posedge clk)
    if (reset) cand <= '0;
    else if (fin) cand <= frame;
`else
  assign publish = 1'b1;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      state_n = scan_en ? S_OUT_SHIFT : S_IDLE;
      S_OUT_SHIFT: state_n = tick && ph && last_out ? S_OUT_LATCH : state;
      S_OUT_LATCH: state_n = tick && ph ? S_IN_LOAD : state;
      S_IN_LOAD:   state_n = tick && ph ? S_IN_SHIFT : state;
      S_IN_SHIFT:  state_n = tick && ph && last_in ? S_GAP : state;
      S_GAP:       state_n = gap_exit ? (scan_en ? S_OUT_SHIFT : S_IDLE) : state;
      default:     state_n = S_IDLE;
    endcase
  end
  // bcnt counts bits in the shift states and ticks in GAP; it restarts on every state entry
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      ph <= 1'b0;
      bcnt <= '0;
      osr0 <= '0;
      osr1 <= '0;
      cap0 <= '0;
      cap1 <= '0;
      cap2 <= '0;
      in_data_0 <= '0;
      in_data_1 <= '0;
      in_data_2 <= '0;
      in_valid <= 1'b0;
    end else begin
      state <= state_n;
      in_valid <= 1'b0;
      if (state_n != state) begin
        ph <= 1'b0;
        bcnt <= '0;
      end else if (tick) begin
        ph <= !ph;
        if (ph || state == S_GAP) bcnt <= bcnt + 16'd1;
      end
      if (start) begin
        osr0 <= out_data_0;
        osr1 <= out_data_1;
      end else if (state == S_OUT_SHIFT && tick && ph) begin
        osr0 <= osr0 << 1;
        osr1 <= osr1 << 1;
      end
      if (sample) begin
        cap0 <= nxt0;
        cap1 <= nxt1;
        cap2 <= nxt2;
      end
      if (fin && publish) begin
        in_data_0 <= nxt0;
        in_data_1 <= nxt1;
        in_data_2 <= nxt2;
        in_valid <= 1'b1;
      end
    end
  assign busy = state != S_IDLE;
  assign out_srclk = state == S_OUT_SHIFT && ph;
  assign out_rclk = state == S_OUT_LATCH && !ph;
  assign out_ser_0 = osr0[OUT_BITS-1];
  assign out_ser_1 = osr1[OUT_BITS-1];
  assign in_shldn = !(state == S_IN_LOAD && !ph);
  assign in_clk = state == S_IN_SHIFT && ph;
endmodule

// File: tb/tb_panel_scan_scheduler.sv
// tb_panel_scan_scheduler: directed checks of frame timing, serial words, capture, refresh and reset
module tb_panel_scan_scheduler;
  import panel_scan_pkg::*;
  logic clk = 1'b0, reset = 1'b1, scan_en = 1'b0, refresh = 1'b0;
  logic [31:0] out_data_0 = '0, out_data_1 = '0;
  logic [23:0] in_data_0, in_data_1, in_data_2;
  logic in_valid, busy, out_srclk, out_rclk, out_ser_0, out_ser_1, in_clk, in_shldn;
  logic in_qh_0, in_qh_1, in_qh_2;
  logic [23:0] ld0 = '0, ld1 = '0, ld2 = '0, m0 = '0, m1 = '0, m2 = '0;
  logic p_inclk = 1'b0, p_srclk = 1'b0, p_rclk = 1'b0, p_busy = 1'b0;
  logic [31:0] w0 = '0, w1 = '0, l0 = '0, l1 = '0;
  int cyc = 0, rises = 0, rclks = 0, valids = 0;
  int rclk_at = 0, rclk_cyc = 0, valid_cyc = 0, idle_cyc = 0;
  int rise_cyc [256];
  int checks = 0, errors = 0;
  int c0, br, bk, bv;
  panel_scan_scheduler dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .refresh(refresh),
    .out_data_0(out_data_0), .out_data_1(out_data_1),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_valid(in_valid), .busy(busy),
    .out_srclk(out_srclk), .out_rclk(out_rclk), .out_ser_0(out_ser_0), .out_ser_1(out_ser_1),
    .in_clk(in_clk), .in_shldn(in_shldn),
    .in_qh_0(in_qh_0), .in_qh_1(in_qh_1), .in_qh_2(in_qh_2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // 165 chain model: parallel load while SH/LD low, shift toward QH on each CLK rise
  always @(negedge clk) begin
    p_inclk <= in_clk;
    if (!in_shldn) begin
      m0 <= ld0;
      m1 <= ld1;
      m2 <= ld2;
    end else if (in_clk && !p_inclk) begin
      m0 <= m0 << 1;
      m1 <= m1 << 1;
      m2 <= m2 << 1;
    end
  end
  assign in_qh_0 = m0[23];
  assign in_qh_1 = m1[23];
  assign in_qh_2 = m2[23];
  // 595 chain model and event recorder
  always @(negedge clk) begin
    p_srclk <= out_srclk;
    p_rclk <= out_rclk;
    p_busy <= busy;
    if (out_srclk && !p_srclk) begin
      rises <= rises + 1;
      rise_cyc[rises % 256] <= cyc;
      w0 <= {w0[30:0], out_ser_0};
      w1 <= {w1[30:0], out_ser_1};
    end
    if (out_rclk && !p_rclk) begin
      rclks <= rclks + 1;
      rclk_at <= rises;
      rclk_cyc <= cyc;
      l0 <= w0;
      l1 <= w1;
    end
    if (in_valid) begin
      valids <= valids + 1;
      valid_cyc <= cyc;
    end
    if (!busy && p_busy) idle_cyc <= cyc;
  end
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [31:0] o0, input logic [31:0] o1,
                        input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    out_data_0 = o0;
    out_data_1 = o1;
    ld0 = a;
    ld1 = b;
    ld2 = c;
    br = rises;
    bk = rclks;
    bv = valids;
    c0 = cyc;
    scan_en = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 1'b0);
    @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_pins"}, {out_srclk, out_rclk, out_ser_0, out_ser_1, in_clk, in_shldn, in_valid, busy}, 8'b0000_0100);
    check({tag, "_data"}, {in_data_0, in_data_1, in_data_2}, 72'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset("rst");
    // single pair; refresh during OUT_SHIFT must be ignored
    launch(32'hA5A5_0F0F, 32'h0000_0001, 24'h123456, 24'hABCDEF, 24'h000FFF);
    scan_en = 1'b0;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_idle("p1_idle");
    check("p1_first_rise", rise_cyc[br % 256], c0 + 5);
    check("p1_rises", rises - br, 32);
    check("p1_word0", l0, 32'hA5A5_0F0F);
    check("p1_word1", l1, 32'h0000_0001);
    check("p1_rclks", rclks - bk, 1);
    check("p1_rclk_after", rclk_at - br, 32);
    check("p1_rclk_cyc", rclk_cyc, c0 + 257);
    check("p1_idle_cyc", idle_cyc, c0 + 529);
`ifdef PANEL_SCAN_CONFIRM_EN
    check("cf0_valid", valids - bv, 0);
    launch(32'h0, 32'h0, 24'h111111, 24'h111111, 24'h111111);
    scan_en = 1'b0;
    wait_idle("cfa_idle");
    check("cfa_valid", valids - bv, 0);
    check("cfa_data", {in_data_0, in_data_1, in_data_2}, 72'd0);
    launch(32'h0, 32'h0, 24'h222222, 24'h222222, 24'h222222);
    scan_en = 1'b0;
    wait_idle("cfb1_idle");
    check("cfb1_valid", valids - bv, 0);
    check("cfb1_data", {in_data_0, in_data_1, in_data_2}, 72'd0);
    launch(32'h0, 32'h0, 24'h222222, 24'h222222, 24'h222222);
    scan_en = 1'b0;
    wait_idle("cfb2_idle");
    check("cfb2_valid", valids - bv, 1);
    check("cfb2_data", {in_data_0, in_data_1, in_data_2}, {24'h222222, 24'h222222, 24'h222222});
`else
    check("p1_valids", valids - bv, 1);
    check("p1_valid_cyc", valid_cyc, c0 + 461);
    check("p1_data", {in_data_0, in_data_1, in_data_2}, {24'h123456, 24'hABCDEF, 24'h000FFF});
`endif
    // scan_en dropped mid IN_SHIFT: pair and full GAP complete, then IDLE
    launch(32'hFFFF_0000, 32'h1234_5678, 24'h000000, 24'hFFFFFF, 24'hA5A5A5);
    while (cyc < c0 + 300) @(negedge clk);
    scan_en = 1'b0;
    wait_idle("drop_idle");
    check("drop_idle_cyc", idle_cyc, c0 + 529);
    check("drop_word0", l0, 32'hFFFF_0000);
    check("drop_word1", l1, 32'h1234_5678);
`ifndef PANEL_SCAN_CONFIRM_EN
    check("drop_data", {in_data_0, in_data_1, in_data_2}, {24'h000000, 24'hFFFFFF, 24'hA5A5A5});
`endif
    repeat (100) @(negedge clk);
    check("drop_no_more", rises - br, 32);
    // refresh on the third GAP tick shortens the pair by 13 ticks
    launch(32'h1234_5678, 32'h8765_4321, 24'h0F0F0F, 24'h00FF00, 24'h800001);
    while (cyc < c0 + 476) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    scan_en = 1'b0;
    wait_idle("ref_idle");
    check("ref_next_rise", rise_cyc[(br + 32) % 256], c0 + 5 + (frame_ticks(32, 24, 16) - 13) * 4);
    check("ref_rises", rises - br, 64);
    check("ref_word0", l0, 32'h1234_5678);
    check("ref_idle_cyc", idle_cyc, c0 + 477 + 528);
    // reset during OUT_SHIFT around bit 10
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 24'h0, 24'h0, 24'h0);
    while (rises - br < 10 && cyc < c0 + 200) @(negedge clk);
    check("mid_bit10", rises - br, 10);
    reset = 1'b1;
    scan_en = 1'b0;
    @(negedge clk);
    check_reset("mid_rst");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_stay_idle", {busy, out_srclk}, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
